uart_tx_fifo: RTL and testbench

Buffered, parametrised UART transmitter, the successor to the single-buffer transmitter in the peripheral set. It holds a configurable-depth byte FIFO and a per-frame latched line format (5–8 data bits, optional parity, 1/2 stop bits). It sends queued frames back-to-back with no idle gap, and has optional CTS flow control. It sits between the bus-side peripheral register block and the Txd pin.

---
 rtl/uart_tx_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with a byte FIFO and a per-frame line format.
//
// Queued bytes are sent back-to-back with no idle gap between frames. The line format
// (data length, parity, stop bits, baud divisor) is sampled when a byte is popped and
// is held for that whole frame, so the configuration inputs may change at any time.
//
// Optional feature macro: UART_TX_CTS_EN
//   When defined, adds the Ctsn input. It is synchronised through two flops, and a new
//   frame starts only while the synchronised Ctsn is low. A frame in flight always completes.
//
// Parameters
//   FIFO_DEPTH      FIFO entries (power of two, >= 2)
//   BAUD_WIDTH      width of BaudLimit
// Ports
//   Clock           system clock, rising edge
//   Reset           asynchronous active-low reset
//   TxWrEn          write strobe, one byte per high cycle
//   TxData          byte to queue, LSB sent first
//   TxFlush         synchronous FIFO clear (frame in flight unaffected)
//   DataLenLimit    data bits - 1 (4..7; 0..3 treated as 4)
//   StopLenLimit    0: one stop bit, 1: two stop bits
//   ParityEn        enable parity bit
//   ParityPolarity  0: even, 1: odd
//   BaudLimit       clocks per bit - 1
//   Ctsn            clear-to-send, active-low (UART_TX_CTS_EN only)
//   TxEmpty         FIFO empty
//   TxFull          FIFO full
//   TxLevel         FIFO occupancy
//   TxOverflow      one-cycle pulse after a dropped write
//   TxBusy          frame on the line
//   Txd             registered serial output

module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BAUD_WIDTH = 16
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          TxWrEn,
    input  logic [7:0]                    TxData,
    input  logic                          TxFlush,
    input  logic [2:0]                    DataLenLimit,
    input  logic                          StopLenLimit,
    input  logic                          ParityEn,
    input  logic                          ParityPolarity,
    input  logic [BAUD_WIDTH-1:0]         BaudLimit,
`ifdef UART_TX_CTS_EN
    input  logic                          Ctsn,
`endif
    output logic                          TxEmpty,
    output logic                          TxFull,
    output logic [$clog2(FIFO_DEPTH):0]   TxLevel,
    output logic                          TxOverflow,
    output logic                          TxBusy,
    output logic                          Txd
);

    localparam int unsigned AddrWidth  = $clog2(FIFO_DEPTH);
    localparam int unsigned LevelWidth = AddrWidth + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } txStateT;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]            fifoMem [FIFO_DEPTH];
    logic [AddrWidth-1:0]  wrPtrQ, wrPtrD;
    logic [AddrWidth-1:0]  rdPtrQ, rdPtrD;
    logic [LevelWidth-1:0] levelQ, levelD;
    logic                  overflowQ, overflowD;

    logic                  fifoEmpty;
    logic                  fifoFull;
    logic                  wrAccept;
    logic                  popEn;
    logic [7:0]            fifoHead;

    assign fifoEmpty = (levelQ == '0);
    assign fifoFull  = (levelQ == LevelWidth'(FIFO_DEPTH));
    assign fifoHead  = fifoMem[rdPtrQ];

    // Fullness is judged before this cycle's pop; a flush swallows the write silently.
    assign wrAccept  = TxWrEn & ~fifoFull & ~TxFlush;
    assign overflowD = TxWrEn & fifoFull & ~TxFlush;

    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        levelD = levelQ;
        if (TxFlush) begin
            wrPtrD = '0;
            rdPtrD = '0;
            levelD = '0;
        end else begin
            if (wrAccept) begin
                wrPtrD = wrPtrQ + 1'b1;
            end
            if (popEn) begin
                rdPtrD = rdPtrQ + 1'b1;
            end
            if (wrAccept && !popEn) begin
                levelD = levelQ + 1'b1;
            end else if (!wrAccept && popEn) begin
                levelD = levelQ - 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            levelQ    <= '0;
            overflowQ <= 1'b0;
        end else begin
            wrPtrQ    <= wrPtrD;
            rdPtrQ    <= rdPtrD;
            levelQ    <= levelD;
            overflowQ <= overflowD;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are valid.
    always_ff @(posedge Clock) begin
        if (wrAccept) begin
            fifoMem[wrPtrQ] <= TxData;
        end
    end

    // ------------------------------------------------------------------
    // Clear-to-send gating
    // ------------------------------------------------------------------
    logic ctsClear;

`ifdef UART_TX_CTS_EN
    logic ctsSync1Q;
    logic ctsSync2Q;

    // Resets to "not clear" so nothing starts until a real low Ctsn has been seen.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ctsSync1Q <= 1'b1;
            ctsSync2Q <= 1'b1;
        end else begin
            ctsSync1Q <= Ctsn;
            ctsSync2Q <= ctsSync1Q;
        end
    end

    assign ctsClear = ~ctsSync2Q;
`else
    assign ctsClear = 1'b1;
`endif

    logic canStart;
    assign canStart = ~fifoEmpty & ctsClear;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    txStateT               stateQ, stateD;
    logic [7:0]            shiftQ, shiftD;
    logic [2:0]            bitIdxQ, bitIdxD;
    logic                  stopIdxQ, stopIdxD;
    logic [BAUD_WIDTH-1:0] baudCntQ, baudCntD;
    logic [BAUD_WIDTH-1:0] baudLimitQ, baudLimitD;
    logic [2:0]            dataLenQ, dataLenD;
    logic                  stopLenQ, stopLenD;
    logic                  parityEnQ, parityEnD;
    logic                  parityBitQ, parityBitD;
    logic                  txdQ, txdD;

    logic                  bitDone;
    logic                  startFrame;
    logic [2:0]            effDataLen;
    logic [7:0]            lenMask;

    assign bitDone = (baudCntQ == '0);

    // Lengths below five data bits are not supported; clamp to five.
    assign effDataLen = DataLenLimit[2] ? DataLenLimit : 3'd4;
    assign lenMask    = 8'hFF >> (3'd7 - effDataLen);

    always_comb begin
        stateD     = stateQ;
        shiftD     = shiftQ;
        bitIdxD    = bitIdxQ;
        stopIdxD   = stopIdxQ;
        baudCntD   = baudCntQ;
        baudLimitD = baudLimitQ;
        dataLenD   = dataLenQ;
        stopLenD   = stopLenQ;
        parityEnD  = parityEnQ;
        parityBitD = parityBitQ;
        txdD       = txdQ;
        popEn      = 1'b0;
        startFrame = 1'b0;

        if (stateQ != StIdle) begin
            baudCntD = bitDone ? baudLimitQ : baudCntQ - 1'b1;
        end

        case (stateQ)
            StIdle: begin
                txdD = 1'b1;
                if (canStart) begin
                    startFrame = 1'b1;
                end
            end

            StStart: begin
                if (bitDone) begin
                    stateD  = StData;
                    bitIdxD = '0;
                    txdD    = shiftQ[0];
                end
            end

            // The bit on the line is always shiftQ[0]; shift on each data boundary.
            StData: begin
                if (bitDone) begin
                    if (bitIdxQ == dataLenQ) begin
                        if (parityEnQ) begin
                            stateD = StParity;
                            txdD   = parityBitQ;
                        end else begin
                            stateD   = StStop;
                            stopIdxD = 1'b0;
                            txdD     = 1'b1;
                        end
                    end else begin
                        bitIdxD = bitIdxQ + 1'b1;
                        shiftD  = shiftQ >> 1;
                        txdD    = shiftQ[1];
                    end
                end
            end

            StParity: begin
                if (bitDone) begin
                    stateD   = StStop;
                    stopIdxD = 1'b0;
                    txdD     = 1'b1;
                end
            end

            StStop: begin
                if (bitDone) begin
                    if (stopIdxQ != stopLenQ) begin
                        stopIdxD = 1'b1;
                    end else if (canStart) begin
                        // Chain directly into the next start bit: no idle cycle.
                        startFrame = 1'b1;
                    end else begin
                        stateD = StIdle;
                        txdD   = 1'b1;
                    end
                end
            end

            default: begin
                stateD = StIdle;
                txdD   = 1'b1;
            end
        endcase

        // Pop the head and freeze the line format for the whole frame.
        if (startFrame) begin
            popEn      = 1'b1;
            stateD     = StStart;
            shiftD     = fifoHead;
            dataLenD   = effDataLen;
            stopLenD   = StopLenLimit;
            parityEnD  = ParityEn;
            parityBitD = (^(fifoHead & lenMask)) ^ ParityPolarity;
            baudLimitD = BaudLimit;
            baudCntD   = BaudLimit;
            txdD       = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stateQ     <= StIdle;
            shiftQ     <= '0;
            bitIdxQ    <= '0;
            stopIdxQ   <= 1'b0;
            baudCntQ   <= '0;
            baudLimitQ <= '0;
            dataLenQ   <= 3'd7;
            stopLenQ   <= 1'b0;
            parityEnQ  <= 1'b0;
            parityBitQ <= 1'b0;
            txdQ       <= 1'b1;
        end else begin
            stateQ     <= stateD;
            shiftQ     <= shiftD;
            bitIdxQ    <= bitIdxD;
            stopIdxQ   <= stopIdxD;
            baudCntQ   <= baudCntD;
            baudLimitQ <= baudLimitD;
            dataLenQ   <= dataLenD;
            stopLenQ   <= stopLenD;
            parityEnQ  <= parityEnD;
            parityBitQ <= parityBitD;
            txdQ       <= txdD;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign TxEmpty    = fifoEmpty;
    assign TxFull     = fifoFull;
    assign TxLevel    = levelQ;
    assign TxOverflow = overflowQ;
    assign TxBusy     = (stateQ != StIdle);
    assign Txd        = txdQ;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.

module tb_uart_tx_fifo;

    localparam int unsigned FifoDepth = 16;
    localparam int unsigned BaudWidth = 16;

    logic                         Clock;
    logic                         Reset;
    logic                         TxWrEn;
    logic [7:0]                   TxData;
    logic                         TxFlush;
    logic [2:0]                   DataLenLimit;
    logic                         StopLenLimit;
    logic                         ParityEn;
    logic                         ParityPolarity;
    logic [BaudWidth-1:0]         BaudLimit;
`ifdef UART_TX_CTS_EN
    logic                         Ctsn;
`endif
    logic                         TxEmpty;
    logic                         TxFull;
    logic [$clog2(FifoDepth):0]   TxLevel;
    logic                         TxOverflow;
    logic                         TxBusy;
    logic                         Txd;

    int vectorCount = 0;
    int missCount   = 0;

    uart_tx_fifo #(
        .FIFO_DEPTH (FifoDepth),
        .BAUD_WIDTH (BaudWidth)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .TxWrEn         (TxWrEn),
        .TxData         (TxData),
        .TxFlush        (TxFlush),
        .DataLenLimit   (DataLenLimit),
        .StopLenLimit   (StopLenLimit),
        .ParityEn       (ParityEn),
        .ParityPolarity (ParityPolarity),
        .BaudLimit      (BaudLimit),
`ifdef UART_TX_CTS_EN
        .Ctsn           (Ctsn),
`endif
        .TxEmpty        (TxEmpty),
        .TxFull         (TxFull),
        .TxLevel        (TxLevel),
        .TxOverflow     (TxOverflow),
        .TxBusy         (TxBusy),
        .Txd            (Txd)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "timeout");
    end

    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called at the falling edge after the start-bit edge; skip drops already-elapsed cycles.
    task automatic checkFrame(input logic [7:0] data, input int nBits, input bit parEn,
                              input bit parBit, input int stops, input int baud,
                              input int skip);
        logic frameBits [12];
        int   nFrame;
        int   cyc;
        frameBits[0] = 1'b0;
        nFrame = 1;
        for (int i = 0; i < nBits; i++) begin
            frameBits[nFrame] = data[i];
            nFrame++;
        end
        if (parEn) begin
            frameBits[nFrame] = parBit;
            nFrame++;
        end
        for (int i = 0; i < stops; i++) begin
            frameBits[nFrame] = 1'b1;
            nFrame++;
        end
        cyc = 0;
        for (int b = 0; b < nFrame; b++) begin
            for (int k = 0; k <= baud; k++) begin
                if (cyc >= skip) begin
                    checkVal($sformatf("txd %02h bit%0d", data, b), 32'(Txd),
                             32'(frameBits[b]));
                    checkVal($sformatf("busy %02h bit%0d", data, b), 32'(TxBusy), 1);
                    @(negedge Clock);
                end
                cyc++;
            end
        end
    endtask

    task automatic writeByte(input logic [7:0] d);
        TxData = d;
        TxWrEn = 1'b1;
        @(negedge Clock);
        TxWrEn = 1'b0;
    endtask

    task automatic checkIdle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            checkVal({tag, " txd"}, 32'(Txd), 1);
            checkVal({tag, " busy"}, 32'(TxBusy), 0);
            @(negedge Clock);
        end
    endtask

    initial begin
        Reset          = 1'b0;
        TxWrEn         = 1'b0;
        TxData         = 8'h00;
        TxFlush        = 1'b0;
        DataLenLimit   = 3'd7;
        StopLenLimit   = 1'b0;
        ParityEn       = 1'b0;
        ParityPolarity = 1'b0;
        BaudLimit      = 16'd3;
`ifdef UART_TX_CTS_EN
        Ctsn           = 1'b0;
`endif
        #12;
        checkVal("reset txd", 32'(Txd), 1);
        checkVal("reset empty", 32'(TxEmpty), 1);
        checkVal("reset full", 32'(TxFull), 0);
        checkVal("reset level", 32'(TxLevel), 0);
        checkVal("reset ovf", 32'(TxOverflow), 0);
        checkVal("reset busy", 32'(TxBusy), 0);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (4) @(negedge Clock);

        // 8N1, 4 cycles per bit, 0x55
        writeByte(8'h55);
        checkVal("8n1 empty after write", 32'(TxEmpty), 0);
        checkVal("8n1 level after write", 32'(TxLevel), 1);
        checkVal("8n1 busy before pop", 32'(TxBusy), 0);
        checkVal("8n1 txd before pop", 32'(Txd), 1);
        @(negedge Clock);
        checkVal("8n1 level after pop", 32'(TxLevel), 0);
        checkFrame(8'h55, 8, 1'b0, 1'b0, 1, 3, 0);
        checkVal("8n1 busy after frame", 32'(TxBusy), 0);
        checkVal("8n1 empty after frame", 32'(TxEmpty), 1);
        checkIdle("8n1 idle", 2);

        // 7E2 and 7O2, 2 cycles per bit, 0x41 (two ones -> even parity 0, odd parity 1)
        DataLenLimit   = 3'd6;
        ParityEn       = 1'b1;
        ParityPolarity = 1'b0;
        StopLenLimit   = 1'b1;
        BaudLimit      = 16'd1;
        writeByte(8'h41);
        @(negedge Clock);
        checkFrame(8'h41, 7, 1'b1, 1'b0, 2, 1, 0);
        checkIdle("7e2 idle", 2);
        ParityPolarity = 1'b1;
        writeByte(8'h41);
        @(negedge Clock);
        checkFrame(8'h41, 7, 1'b1, 1'b1, 2, 1, 0);
        checkIdle("7o2 idle", 2);

        // Overflow: 18 back-to-back writes, 10 cycles per bit, 8N1
        DataLenLimit   = 3'd7;
        ParityEn       = 1'b0;
        ParityPolarity = 1'b0;
        StopLenLimit   = 1'b0;
        BaudLimit      = 16'd9;
        for (int i = 0; i < 18; i++) begin
            TxData = 8'(i);
            TxWrEn = 1'b1;
            @(negedge Clock);
            checkVal($sformatf("fill ovf %0d", i), 32'(TxOverflow), 32'(i == 17));
            checkVal($sformatf("fill level %0d", i), 32'(TxLevel),
                     (i == 0) ? 1 : ((i > 16) ? 16 : i));
            checkVal($sformatf("fill full %0d", i), 32'(TxFull), 32'(i >= 16));
        end
        TxWrEn = 1'b0;
        @(negedge Clock);
        checkVal("ovf one cycle", 32'(TxOverflow), 0);
        checkVal("still full", 32'(TxFull), 1);
        checkFrame(8'h00, 8, 1'b0, 1'b0, 1, 9, 17);
        for (int j = 1; j <= 16; j++) begin
            checkFrame(8'(j), 8, 1'b0, 1'b0, 1, 9, 0);
        end
        checkVal("burst empty at end", 32'(TxEmpty), 1);
        checkIdle("burst idle", 2);

        // Flush during the first frame: that frame finishes, the rest is dropped
        BaudLimit = 16'd1;
        for (int i = 0; i < 5; i++) begin
            TxData = 8'h11 + 8'(i);
            TxWrEn = 1'b1;
            @(negedge Clock);
        end
        checkVal("flush level before", 32'(TxLevel), 4);
        TxWrEn  = 1'b0;
        TxFlush = 1'b1;
        @(negedge Clock);
        TxFlush = 1'b0;
        checkVal("flush level after", 32'(TxLevel), 0);
        checkVal("flush empty after", 32'(TxEmpty), 1);
        checkVal("flush busy", 32'(TxBusy), 1);
        checkFrame(8'h11, 8, 1'b0, 1'b0, 1, 1, 4);
        checkIdle("flush idle", 4);

        // Baud change mid-frame applies to the next frame only
        BaudLimit = 16'd3;
        TxData    = 8'hA3;
        TxWrEn    = 1'b1;
        @(negedge Clock);
        TxData = 8'h5C;
        @(negedge Clock);
        TxWrEn    = 1'b0;
        BaudLimit = 16'd7;
        checkFrame(8'hA3, 8, 1'b0, 1'b0, 1, 3, 0);
        checkFrame(8'h5C, 8, 1'b0, 1'b0, 1, 7, 0);
        checkIdle("baud idle", 2);

        // Flush and write together: write discarded, no overflow
        TxData  = 8'hFF;
        TxWrEn  = 1'b1;
        TxFlush = 1'b1;
        @(negedge Clock);
        TxWrEn  = 1'b0;
        TxFlush = 1'b0;
        checkVal("flushwr level", 32'(TxLevel), 0);
        checkVal("flushwr ovf", 32'(TxOverflow), 0);
        checkIdle("flushwr idle", 3);

        // DataLenLimit=2 acts as 5 bits; BaudLimit=0; parity over low 5 bits of 0xEA only
        DataLenLimit = 3'd2;
        ParityEn     = 1'b1;
        BaudLimit    = 16'd0;
        writeByte(8'hEA);
        @(negedge Clock);
        checkFrame(8'hEA, 5, 1'b1, 1'b0, 1, 0, 0);
        checkIdle("5e1 idle", 2);

        // Asynchronous reset mid-frame
        DataLenLimit = 3'd7;
        ParityEn     = 1'b0;
        BaudLimit    = 16'd3;
        TxData       = 8'h00;
        TxWrEn       = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        TxWrEn = 1'b0;
        repeat (3) @(negedge Clock);
        checkVal("pre-reset txd", 32'(Txd), 0);
        checkVal("pre-reset level", 32'(TxLevel), 1);
        #2;
        Reset = 1'b0;
        #1;
        checkVal("async reset txd", 32'(Txd), 1);
        checkVal("async reset busy", 32'(TxBusy), 0);
        checkVal("async reset level", 32'(TxLevel), 0);
        checkVal("async reset empty", 32'(TxEmpty), 1);
        @(negedge Clock);
        Reset = 1'b1;
        checkIdle("post-reset idle", 4);

`ifdef UART_TX_CTS_EN
        // CTS gating: nothing starts while Ctsn is high; 3-cycle start latency
        BaudLimit = 16'd1;
        Ctsn      = 1'b1;
        repeat (3) @(negedge Clock);
        writeByte(8'hA5);
        writeByte(8'h3C);
        checkIdle("cts held", 5);
        checkVal("cts held level", 32'(TxLevel), 2);
        Ctsn = 1'b0;
        @(negedge Clock);
        checkVal("cts lat1 txd", 32'(Txd), 1);
        @(negedge Clock);
        checkVal("cts lat2 txd", 32'(Txd), 1);
        @(negedge Clock);
        Ctsn = 1'b1;
        checkFrame(8'hA5, 8, 1'b0, 1'b0, 1, 1, 0);
        checkIdle("cts second held", 5);
        checkVal("cts second level", 32'(TxLevel), 1);
        Ctsn = 1'b0;
        @(negedge Clock);
        checkVal("cts2 lat1 txd", 32'(Txd), 1);
        @(negedge Clock);
        checkVal("cts2 lat2 txd", 32'(Txd), 1);
        @(negedge Clock);
        checkFrame(8'h3C, 8, 1'b0, 1'b0, 1, 1, 0);
        checkIdle("cts done idle", 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
